// File: rtl/forwarding_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_scoreboard_pkg
// Description : Default geometry and slot/tag types for the forwarding scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package forwarding_scoreboard_pkg;

    localparam int C_WORD_W   = 32;
    localparam int C_REG_W    = 5;
    localparam int C_DEPTH    = 4;
    localparam int C_NUM_READ = 2;
    localparam int C_NUM_RES  = 2;
    localparam int C_TAG_W    = $clog2(C_DEPTH) + 1;

    typedef logic [C_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic                valid;
        logic [C_REG_W-1:0]  dst;
        tag_t                tag;
        logic                rdy;
        logic [C_WORD_W-1:0] data;
    } fwd_slot_t;

endpackage
`default_nettype wire

// File: rtl/forwarding_scoreboard_lookup.sv
`default_nettype none
// ============================================================================
// Module      : fwd_lookup
// Description : Priority search of one operand over the slots and result buses.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_lookup
    import forwarding_scoreboard_pkg::*;
#(
    parameter int WORD_W  = C_WORD_W,
    parameter int REG_W   = C_REG_W,
    parameter int DEPTH   = C_DEPTH,
    parameter int NUM_RES = C_NUM_RES,
    parameter int TAG_W   = $clog2(DEPTH) + 1
) (
    input  logic [REG_W-1:0]          i_rdReg,
    input  logic [DEPTH-1:0]          i_slotValid,
    input  logic [DEPTH-1:0]          i_slotRdy,
    input  logic [DEPTH*REG_W-1:0]    i_slotDst,
    input  logic [DEPTH*TAG_W-1:0]    i_slotTag,
    input  logic [DEPTH*WORD_W-1:0]   i_slotData,
    input  logic [NUM_RES-1:0]        i_resValid,
    input  logic [NUM_RES*TAG_W-1:0]  i_resTag,
    input  logic [NUM_RES*WORD_W-1:0] i_resData,
    output logic                      o_hit,
    output logic [WORD_W-1:0]         o_data,
    output logic                      o_stall
);

    logic              w_found;
    logic              w_rdy;
    logic [TAG_W-1:0]  w_tag;
    logic [WORD_W-1:0] w_slotData;
    logic              w_busHit;
    logic [WORD_W-1:0] w_busData;

    // Descending scans so the lowest index (youngest slot / lowest bus) wins.
    always_comb begin
        w_found    = 1'b0;
        w_rdy      = 1'b0;
        w_tag      = '0;
        w_slotData = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_slotValid[k] && (i_slotDst[k*REG_W +: REG_W] == i_rdReg)) begin
                w_found    = 1'b1;
                w_rdy      = i_slotRdy[k];
                w_tag      = i_slotTag[k*TAG_W +: TAG_W];
                w_slotData = i_slotData[k*WORD_W +: WORD_W];
            end
        end
        if (i_rdReg == '0) begin
            w_found = 1'b0;
        end

        w_busHit  = 1'b0;
        w_busData = '0;
        for (int j = NUM_RES - 1; j >= 0; j--) begin
            if (i_resValid[j] && (i_resTag[j*TAG_W +: TAG_W] == w_tag)) begin
                w_busHit  = 1'b1;
                w_busData = i_resData[j*WORD_W +: WORD_W];
            end
        end

        o_hit   = w_found && (w_rdy || w_busHit);
        o_data  = w_rdy ? w_slotData : w_busData;
        o_stall = w_found && !w_rdy && !w_busHit;
    end

endmodule
`default_nettype wire

// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_scoreboard
// Description : In-order tracker of in-flight register writes with tagged
//               result capture, operand forwarding and stall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter int WORD_W   = C_WORD_W,
    parameter int REG_W    = C_REG_W,
    parameter int DEPTH    = C_DEPTH,
    parameter int NUM_READ = C_NUM_READ,
    parameter int NUM_RES  = C_NUM_RES,
    parameter int TAG_W    = $clog2(DEPTH) + 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       adv,
    input  logic                       iss_valid,
    input  logic                       iss_wen,
    input  logic [REG_W-1:0]           iss_dst,
    output logic [TAG_W-1:0]           iss_tag,
    input  logic [NUM_RES-1:0]         res_valid,
    input  logic [NUM_RES*TAG_W-1:0]   res_tag,
    input  logic [NUM_RES*WORD_W-1:0]  res_data,
    input  logic [NUM_READ*REG_W-1:0]  rd_reg,
    output logic [NUM_READ-1:0]        fwd_hit,
    output logic [NUM_READ*WORD_W-1:0] fwd_data,
    output logic                       stall,
    input  logic [DEPTH-1:0]           flush_mask,
    output logic                       ret_valid,
    output logic [REG_W-1:0]           ret_reg,
    output logic [WORD_W-1:0]          ret_data,
    output logic                       err
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [TAG_W-1:0]  tag;
        logic              rdy;
        logic [WORD_W-1:0] data;
    } slot_t;

    slot_t r_slot [DEPTH];
    slot_t w_upd  [DEPTH];
    slot_t w_new;
    logic [TAG_W-1:0] r_tagCnt;
    logic             r_err;

    logic [DEPTH-1:0]        w_slotValid;
    logic [DEPTH-1:0]        w_slotRdy;
    logic [DEPTH*REG_W-1:0]  w_slotDst;
    logic [DEPTH*TAG_W-1:0]  w_slotTag;
    logic [DEPTH*WORD_W-1:0] w_slotData;
    logic [NUM_READ-1:0]     w_portStall;
    logic                    w_unused;

    // Each slot after flush and result capture, before any shift.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_upd[k]       = r_slot[k];
            w_upd[k].valid = r_slot[k].valid & ~flush_mask[k];
            if (r_slot[k].valid && !r_slot[k].rdy) begin
                for (int j = NUM_RES - 1; j >= 0; j--) begin
                    if (res_valid[j] && (res_tag[j*TAG_W +: TAG_W] == r_slot[k].tag)) begin
                        w_upd[k].rdy  = 1'b1;
                        w_upd[k].data = res_data[j*WORD_W +: WORD_W];
                    end
                end
            end
        end
        w_new.valid = iss_valid & iss_wen & (iss_dst != '0);
        w_new.dst   = iss_dst;
        w_new.tag   = r_tagCnt;
        w_new.rdy   = 1'b0;
        w_new.data  = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
            r_tagCnt <= '0;
            r_err    <= 1'b0;
        end else if (adv) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_slot[k] <= w_upd[k-1];
            end
            r_slot[0] <= w_new;
            if (iss_valid) begin
                r_tagCnt <= r_tagCnt + TAG_W'(1);
            end
            if (r_slot[DEPTH-1].valid && !w_upd[DEPTH-1].rdy) begin
                r_err <= 1'b1;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= w_upd[k];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign w_slotValid[k]                  = r_slot[k].valid;
        assign w_slotRdy[k]                    = r_slot[k].rdy;
        assign w_slotDst[k*REG_W +: REG_W]     = r_slot[k].dst;
        assign w_slotTag[k*TAG_W +: TAG_W]     = r_slot[k].tag;
        assign w_slotData[k*WORD_W +: WORD_W]  = r_slot[k].data;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        fwd_lookup #(
            .WORD_W  (WORD_W),
            .REG_W   (REG_W),
            .DEPTH   (DEPTH),
            .NUM_RES (NUM_RES),
            .TAG_W   (TAG_W)
        ) u_lookup (
            .i_rdReg     (rd_reg[i*REG_W +: REG_W]),
            .i_slotValid (w_slotValid),
            .i_slotRdy   (w_slotRdy),
            .i_slotDst   (w_slotDst),
            .i_slotTag   (w_slotTag),
            .i_slotData  (w_slotData),
            .i_resValid  (res_valid),
            .i_resTag    (res_tag),
            .i_resData   (res_data),
            .o_hit       (fwd_hit[i]),
            .o_data      (fwd_data[i*WORD_W +: WORD_W]),
            .o_stall     (w_portStall[i])
        );
    end

    assign stall     = |w_portStall;
    assign iss_tag   = r_tagCnt;
    assign ret_valid = adv & r_slot[DEPTH-1].valid;
    assign ret_reg   = r_slot[DEPTH-1].dst;
    assign ret_data  = w_upd[DEPTH-1].data;
    assign err       = r_err;
    assign w_unused  = ^{w_upd[DEPTH-1].valid, w_upd[DEPTH-1].tag, w_upd[DEPTH-1].dst};

endmodule
`default_nettype wire

// File: tb/tb_forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_forwarding_scoreboard
// Description : Directed scenarios plus randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_scoreboard;

    localparam int WORD_W = 32, REG_W = 5, DEPTH = 4, NUM_READ = 2, NUM_RES = 2, TAG_W = 3;

    logic CLK, RST, adv, iss_valid, iss_wen;
    logic [REG_W-1:0]           iss_dst;
    logic [TAG_W-1:0]           iss_tag;
    logic [NUM_RES-1:0]         res_valid;
    logic [NUM_RES*TAG_W-1:0]   res_tag;
    logic [NUM_RES*WORD_W-1:0]  res_data;
    logic [NUM_READ*REG_W-1:0]  rd_reg;
    logic [NUM_READ-1:0]        fwd_hit;
    logic [NUM_READ*WORD_W-1:0] fwd_data;
    logic                       stall;
    logic [DEPTH-1:0]           flush_mask;
    logic                       ret_valid;
    logic [REG_W-1:0]           ret_reg;
    logic [WORD_W-1:0]          ret_data;
    logic                       err;

    int total = 0;
    int bad   = 0;

    // Program-order model: index 0 youngest, back of queue retires next.
    typedef struct { bit valid; int dst; int tag; bit rdy; logic [31:0] data; } ent_t;
    ent_t mq[$];
    int   mTagCnt;
    bit   mErr;

    forwarding_scoreboard #(
        .WORD_W(WORD_W), .REG_W(REG_W), .DEPTH(DEPTH),
        .NUM_READ(NUM_READ), .NUM_RES(NUM_RES), .TAG_W(TAG_W)
    ) dut (
        .CLK(CLK), .RST(RST), .adv(adv), .iss_valid(iss_valid), .iss_wen(iss_wen),
        .iss_dst(iss_dst), .iss_tag(iss_tag), .res_valid(res_valid), .res_tag(res_tag),
        .res_data(res_data), .rd_reg(rd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .stall(stall), .flush_mask(flush_mask), .ret_valid(ret_valid), .ret_reg(ret_reg),
        .ret_data(ret_data), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic void busFind(input int tag, output bit hit, output logic [31:0] d);
        hit = 0;
        d   = '0;
        for (int j = 0; j < NUM_RES; j++) begin
            if (!hit && res_valid[j] && int'(res_tag[j*TAG_W +: TAG_W]) == tag) begin
                hit = 1;
                d   = res_data[j*WORD_W +: WORD_W];
            end
        end
    endfunction

    function automatic void expLook(input int p, output bit hit, output logic [31:0] d, output bit stl);
        int r;
        bit bh;
        logic [31:0] bd;
        r   = int'(rd_reg[p*REG_W +: REG_W]);
        hit = 0;
        d   = '0;
        stl = 0;
        if (r == 0) return;
        for (int k = 0; k < DEPTH; k++) begin
            if (mq[k].valid && mq[k].dst == r) begin
                if (mq[k].rdy) begin
                    hit = 1;
                    d   = mq[k].data;
                end else begin
                    busFind(mq[k].tag, bh, bd);
                    if (bh) begin
                        hit = 1;
                        d   = bd;
                    end else begin
                        stl = 1;
                    end
                end
                return;
            end
        end
    endfunction

    task automatic modelEdge();
        ent_t nq[$];
        ent_t e;
        bit h;
        logic [31:0] d;
        if (RST) begin
            mq.delete();
            e = '{valid: 0, dst: 0, tag: 0, rdy: 0, data: '0};
            for (int k = 0; k < DEPTH; k++) mq.push_back(e);
            mTagCnt = 0;
            mErr    = 0;
            return;
        end
        nq = mq;
        for (int k = 0; k < DEPTH; k++) begin
            if (mq[k].valid && !mq[k].rdy) begin
                busFind(mq[k].tag, h, d);
                if (h) begin
                    nq[k].rdy  = 1;
                    nq[k].data = d;
                end
            end
            if (flush_mask[k]) nq[k].valid = 0;
        end
        if (adv) begin
            if (mq[DEPTH-1].valid && !nq[DEPTH-1].rdy) mErr = 1;
            void'(nq.pop_back());
            e = '{valid: (iss_valid && iss_wen && iss_dst != 0), dst: int'(iss_dst),
                  tag: mTagCnt, rdy: 0, data: '0};
            nq.push_front(e);
            if (iss_valid) mTagCnt = (mTagCnt + 1) % (1 << TAG_W);
        end
        mq = nq;
    endtask

    task automatic tick();
        @(posedge CLK);
        modelEdge();
        #1;
    endtask

    task automatic idle();
        adv = 0; iss_valid = 0; iss_wen = 0; iss_dst = '0;
        res_valid = '0; res_tag = '0; res_data = '0; rd_reg = '0; flush_mask = '0;
    endtask

    task automatic doReset();
        RST = 1;
        idle();
        tick();
        RST = 0;
    endtask

    task automatic issue(input int dst);
        adv = 1; iss_valid = 1; iss_wen = 1; iss_dst = REG_W'(dst);
        tick();
    endtask

    task automatic test_reset();
        doReset();
        adv = 1; rd_reg = {5'd3, 5'd4}; #1;
        total++; if (fwd_hit !== 2'b00) begin bad++; $display("FAIL reset_hit got=%b want=00", fwd_hit); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL reset_ret got=%b want=0", ret_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (iss_tag !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", iss_tag); end
        tick();
        idle();
    endtask

    task automatic test_forward();
        doReset();
        adv = 1; iss_valid = 1; iss_wen = 1; iss_dst = 5'd3; #1;
        total++; if (iss_tag !== 3'd0) begin bad++; $display("FAIL fwd_isstag got=%0d want=0", iss_tag); end
        tick();
        idle();
        res_valid = 2'b01; res_tag = {3'd0, 3'd0}; res_data = {32'h0, 32'hDEAD}; rd_reg = {5'd0, 5'd3}; #1;
        total++; if (fwd_hit[0] !== 1'b1 || fwd_data[31:0] !== 32'hDEAD) begin bad++;
            $display("FAIL fwd_samecycle got=%b/%h want=1/0000dead", fwd_hit[0], fwd_data[31:0]); end
        tick();
        idle();
        rd_reg = {5'd0, 5'd3}; #1;
        total++; if (fwd_hit !== 2'b01) begin bad++; $display("FAIL fwd_hit got=%b want=01", fwd_hit); end
        total++; if (fwd_data[31:0] !== 32'hDEAD) begin bad++; $display("FAIL fwd_data got=%h want=0000dead", fwd_data[31:0]); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_stall got=%b want=0", stall); end
        total++; if (iss_tag !== 3'd1) begin bad++; $display("FAIL fwd_tagcnt got=%0d want=1", iss_tag); end
    endtask

    task automatic test_younger_priority();
        doReset();
        issue(5);
        issue(5);
        idle();
        res_valid = 2'b01; res_tag = {3'd0, 3'd0}; res_data = {32'h0, 32'h11};
        tick();
        idle();
        rd_reg = {5'd5, 5'd5}; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL young_stall got=%b want=1", stall); end
        total++; if (fwd_hit !== 2'b00) begin bad++; $display("FAIL young_nohit got=%b want=00", fwd_hit); end
        res_valid = 2'b10; res_tag = {3'd1, 3'd0}; res_data = {32'h22, 32'h0}; #1;
        total++; if (fwd_hit !== 2'b11 || fwd_data !== {32'h22, 32'h22}) begin bad++;
            $display("FAIL young_bypass got=%b/%h want=11/%h", fwd_hit, fwd_data, {32'h22, 32'h22}); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL young_bypass_stall got=%b want=0", stall); end
        res_valid = 2'b11; res_tag = {3'd1, 3'd1}; res_data = {32'h44, 32'h33}; #1;
        total++; if (fwd_data[31:0] !== 32'h33) begin bad++; $display("FAIL bus_prio got=%h want=00000033", fwd_data[31:0]); end
        tick();
        idle();
        rd_reg = {5'd5, 5'd0}; #1;
        total++; if (fwd_hit !== 2'b10 || fwd_data[63:32] !== 32'h33) begin bad++;
            $display("FAIL capture_prio got=%b/%h want=10/00000033", fwd_hit, fwd_data[63:32]); end
    endtask

    task automatic test_zero_reg();
        doReset();
        issue(0);
        idle();
        #1;
        total++; if (fwd_hit !== 2'b00 || stall !== 1'b0) begin bad++;
            $display("FAIL zero_lookup got=%b/%b want=00/0", fwd_hit, stall); end
        total++; if (iss_tag !== 3'd1) begin bad++; $display("FAIL zero_tagcnt got=%0d want=1", iss_tag); end
        for (int i = 0; i < DEPTH; i++) begin
            adv = 1; #1;
            total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL zero_ret step=%0d got=%b want=0", i, ret_valid); end
            tick();
        end
        idle();
    endtask

    task automatic test_retire();
        doReset();
        for (int n = 1; n <= 4; n++) issue(n);
        idle();
        res_valid = 2'b11; res_tag = {3'd1, 3'd0}; res_data = {32'h102, 32'h101};
        tick();
        res_tag = {3'd3, 3'd2}; res_data = {32'h104, 32'h103};
        tick();
        idle();
        for (int n = 1; n <= 4; n++) begin
            adv = 1; #1;
            total++; if (ret_valid !== 1'b1 || ret_reg !== REG_W'(n) || ret_data !== 32'(32'h100 + n)) begin bad++;
                $display("FAIL retire n=%0d got=%b/%0d/%h want=1/%0d/%h", n, ret_valid, ret_reg, ret_data, n, 32'h100 + n); end
            tick();
        end
        adv = 1; #1;
        total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL retire_empty got=%b want=0", ret_valid); end
        tick();
        idle();
    endtask

    task automatic test_flush_err();
        doReset();
        issue(7);
        idle();
        flush_mask = 4'b0001;
        tick();
        idle();
        rd_reg = {5'd0, 5'd7}; #1;
        total++; if (fwd_hit !== 2'b00 || stall !== 1'b0) begin bad++;
            $display("FAIL flush_lookup got=%b/%b want=00/0", fwd_hit, stall); end
        issue(9);
        idle();
        adv = 1;
        tick(); tick(); tick();
        #1;
        total++; if (ret_valid !== 1'b1 || ret_reg !== 5'd9) begin bad++;
            $display("FAIL err_ret got=%b/%0d want=1/9", ret_valid, ret_reg); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early got=%b want=0", err); end
        tick();
        idle(); #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err); end
        tick(); tick(); #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    endtask

    task automatic test_rst_mid();
        issue(1);
        issue(2);
        issue(3);
        idle();
        rd_reg = {5'd2, 5'd3}; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_stall got=%b want=1", stall); end
        RST = 1;
        tick();
        RST = 0;
        idle();
        adv = 1; rd_reg = {5'd2, 5'd3}; #1;
        total++; if (fwd_hit !== 2'b00 || stall !== 1'b0) begin bad++;
            $display("FAIL mid_lookup got=%b/%b want=00/0", fwd_hit, stall); end
        total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL mid_ret got=%b want=0", ret_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", err); end
        total++; if (iss_tag !== 3'd0) begin bad++; $display("FAIL mid_tag got=%0d want=0", iss_tag); end
        tick();
        idle();
    endtask

    task automatic test_random();
        bit eh, es, anyStall, bh;
        logic [31:0] ed, bd;
        doReset();
        for (int c = 0; c < 600; c++) begin
            RST        = ($urandom_range(0, 99) == 0);
            adv        = ($urandom_range(0, 9) < 6);
            iss_valid  = ($urandom_range(0, 3) != 0);
            iss_wen    = ($urandom_range(0, 3) != 0);
            iss_dst    = REG_W'($urandom_range(0, 7));
            res_valid  = NUM_RES'($urandom);
            res_tag    = (NUM_RES*TAG_W)'($urandom);
            res_data   = {$urandom, $urandom};
            rd_reg     = {REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7))};
            flush_mask = ($urandom_range(0, 9) == 0) ? DEPTH'($urandom) : '0;
            #1;
            anyStall = 0;
            for (int p = 0; p < NUM_READ; p++) begin
                expLook(p, eh, ed, es);
                anyStall |= es;
                total++; if (fwd_hit[p] !== eh) begin bad++;
                    $display("FAIL rand_hit c=%0d p=%0d got=%b want=%b", c, p, fwd_hit[p], eh); end
                if (eh) begin
                    total++; if (fwd_data[p*WORD_W +: WORD_W] !== ed) begin bad++;
                        $display("FAIL rand_data c=%0d p=%0d got=%h want=%h", c, p, fwd_data[p*WORD_W +: WORD_W], ed); end
                end
            end
            total++; if (stall !== anyStall) begin bad++; $display("FAIL rand_stall c=%0d got=%b want=%b", c, stall, anyStall); end
            total++; if (ret_valid !== (adv && mq[DEPTH-1].valid)) begin bad++;
                $display("FAIL rand_ret c=%0d got=%b want=%b", c, ret_valid, adv && mq[DEPTH-1].valid); end
            if (adv && mq[DEPTH-1].valid) begin
                total++; if (ret_reg !== REG_W'(mq[DEPTH-1].dst)) begin bad++;
                    $display("FAIL rand_retreg c=%0d got=%0d want=%0d", c, ret_reg, mq[DEPTH-1].dst); end
                busFind(mq[DEPTH-1].tag, bh, bd);
                if (mq[DEPTH-1].rdy || bh) begin
                    total++; if (ret_data !== (mq[DEPTH-1].rdy ? mq[DEPTH-1].data : bd)) begin bad++;
                        $display("FAIL rand_retdata c=%0d got=%h want=%h", c, ret_data, mq[DEPTH-1].rdy ? mq[DEPTH-1].data : bd); end
                end
            end
            total++; if (err !== mErr) begin bad++; $display("FAIL rand_err c=%0d got=%b want=%b", c, err, mErr); end
            total++; if (int'(iss_tag) !== mTagCnt) begin bad++; $display("FAIL rand_tag c=%0d got=%0d want=%0d", c, iss_tag, mTagCnt); end
            tick();
        end
        RST = 0;
        idle();
    endtask

    initial begin
        RST = 1;
        idle();
        test_reset();
        test_forward();
        test_younger_priority();
        test_zero_reg();
        test_retire();
        test_flush_err();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
